// File: rtl/fsic_sram_pkg.sv
// Shared sizing for the SRAM-backed stream FIFO: SRAM1RW64x128 geometry plus
// the depth of the flop output buffer that hides the macro read latency.
package fsic_sram_pkg;
  localparam int DW       = 128;
  localparam int AW       = 6;
  localparam int DEPTH    = 64;
  localparam int OB_DEPTH = 2;
endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry register FIFO that receives SRAM read data and presents the head
// word to the read stream; e0 is always the head.
module sram_fifo_obuf
  import fsic_sram_pkg::*;
#(
  parameter int DW = fsic_sram_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);

  localparam logic [1:0] OB_FULL = 2'(OB_DEPTH);

  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new word goes behind the survivor.
        if (cnt_q == OB_FULL) begin
          e0_d = e1_q;
          e1_d = push_data;
        end else begin
          e0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign head = e0_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Stream FIFO using an external single-port SRAM for bulk storage plus a
// two-word flop output buffer; reads and writes share the one SRAM port.
module sram_fifo_ctrl
  import fsic_sram_pkg::*;
#(
  parameter int DW = fsic_sram_pkg::DW,
  parameter int AW = fsic_sram_pkg::AW
) (
  input  logic          axis_clk,
  input  logic          axis_rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic [AW-1:0] sram_a,
  output logic          sram_csb,
  output logic          sram_web,
  output logic          sram_oeb,
  output logic [DW-1:0] sram_i,
  input  logic [DW-1:0] sram_o,
  output logic [AW:0]   fifo_level
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   sram_cnt_q, sram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          prio_rd_q, prio_rd_d;
  logic [AW:0]   fifo_level_q, fifo_level_d;

  logic [1:0] ob_cnt, ob_cnt_nxt;
  logic       full, rd_elig, wr_issue, rd_issue, pop;

  always_comb begin
    full    = (sram_cnt_q == FULL_CNT);
    // A read is only launched if the OB is guaranteed a free slot when its data lands.
    rd_elig = (sram_cnt_q != '0) && ((ob_cnt + {1'b0, rd_pend_q}) < 2'd2);
    s_tready = !axis_rst && !full && !(rd_elig && prio_rd_q);
    wr_issue = s_tvalid && s_tready;
    rd_issue = !axis_rst && rd_elig && !wr_issue;
    pop      = m_tvalid && m_tready;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    prio_rd_d  = prio_rd_q;
    rd_pend_d  = rd_issue;
    if (wr_issue) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q + 1'b1;
      prio_rd_d  = 1'b1;
    end else if (rd_issue) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q - 1'b1;
      prio_rd_d  = 1'b0;
    end

    ob_cnt_nxt   = ob_cnt + {1'b0, rd_pend_q} - {1'b0, pop};
    fifo_level_d = sram_cnt_d + {{AW{1'b0}}, rd_pend_d}
                 + {{(AW-1){1'b0}}, ob_cnt_nxt};

    sram_csb = !(wr_issue || rd_issue);
    sram_web = !wr_issue;
    sram_oeb = 1'b0;
    sram_a   = '0;
    sram_i   = '0;
    if (wr_issue) begin
      sram_a = wr_ptr_q;
      sram_i = s_tdata;
    end else if (rd_issue) begin
      sram_a = rd_ptr_q;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sram_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      prio_rd_q    <= 1'b1;
      fifo_level_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sram_cnt_q   <= sram_cnt_d;
      rd_pend_q    <= rd_pend_d;
      prio_rd_q    <= prio_rd_d;
      fifo_level_q <= fifo_level_d;
    end
  end

  // Macro output is valid the cycle after a read issue; rd_pend marks that cycle.
  sram_fifo_obuf #(.DW(DW)) u_obuf (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .push      (rd_pend_q),
    .push_data (sram_o),
    .pop       (pop),
    .head      (m_tdata),
    .cnt       (ob_cnt)
  );

  assign m_tvalid   = (ob_cnt != 2'd0);
  assign fifo_level = fifo_level_q;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural SRAM1RW64x128 model
// and a queue scoreboard of accepted-but-not-yet-delivered words.
module tb_sram_fifo_ctrl;
  localparam int DW = 128;
  localparam int AW = 6;

  logic          axis_clk;
  logic          axis_rst;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [AW-1:0] sram_a;
  logic          sram_csb;
  logic          sram_web;
  logic          sram_oeb;
  logic [DW-1:0] sram_i;
  logic [DW-1:0] sram_o;
  logic [AW:0]   fifo_level;

  sram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .sram_a     (sram_a),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_oeb   (sram_oeb),
    .sram_i     (sram_i),
    .sram_o     (sram_o),
    .fifo_level (fifo_level)
  );

  // Single-port synchronous SRAM: write or registered read on the clock edge.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] sram_q;
  always @(posedge axis_clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else           sram_q      <= mem[sram_a];
    end
  end
  assign sram_o = sram_oeb ? '0 : sram_q;

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  logic [DW-1:0] sb [$];
  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_pop = 0;
  bit alt_chk = 0;
  bit prev_op_valid = 0;
  logic prev_web = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; runs one clock.
  task automatic tick();
    logic [DW-1:0] e;
    #1;
    check("level", fifo_level, sb.size());
    if (alt_chk) begin
      check("op_busy", sram_csb, 1'b0);
      if (!sram_csb) begin
        if (prev_op_valid) check("alt_op", sram_web, !prev_web);
        prev_web = sram_web;
        prev_op_valid = 1;
      end
    end
    if (s_tvalid && s_tready) begin
      sb.push_back(s_tdata);
      n_acc++;
    end
    if (m_tvalid && m_tready) begin
      n_pop++;
      check("pop_has_exp", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("m_tdata", m_tdata, e);
      end
    end
    @(negedge axis_clk);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int a0 = n_acc;
    s_tvalid = 1'b1;
    s_tdata  = d;
    for (int i = 0; i < 20 && n_acc == a0; i++) tick();
    s_tvalid = 1'b0;
    check("push_accept", n_acc - a0, 1);
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
    check("drain_empty", sb.size(), 0);
    tick();
    check("drain_level", fifo_level, 0);
    m_tready = 1'b0;
  endtask

  initial begin
    int a0;
    int p0;
    axis_rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (2) @(negedge axis_clk);
    #1;
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_csb", sram_csb, 1'b1);
    check("rst_level", fifo_level, 0);
    @(negedge axis_clk);
    axis_rst = 1'b0;
    #1;
    check("post_rst_s_tready", s_tready, 1'b1);

    // Three words with the read side stalled
    push_word(128'hA);
    push_word(128'hB);
    push_word(128'hC);
    repeat (5) tick();
    check("three_level", fifo_level, 3);
    check("three_m_tvalid", m_tvalid, 1'b1);
    check("three_head", m_tdata, 128'hA);
    repeat (3) begin
      tick();
      check("hold_head", m_tdata, 128'hA);
    end
    drain();

    // Fill to 66 words; then a single pop admits exactly one more
    a0 = n_acc;
    s_tvalid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      s_tdata = 128'h3400 + 128'(n_acc - a0);
      tick();
    end
    check("fill_count", n_acc - a0, 66);
    check("fill_s_tready", s_tready, 1'b0);
    check("fill_level", fifo_level, 66);
    check("fill_sram_cnt", dut.sram_cnt_q, 64);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_tdata = 128'h3400 + 128'(n_acc - a0);
      tick();
    end
    check("refill_count", n_acc - a0, 67);
    check("refill_level", fifo_level, 66);
    check("refill_s_tready", s_tready, 1'b0);
    drain();

    // Streaming through: SRAM port alternates write/read every cycle
    a0 = n_acc;
    alt_chk = 1;
    prev_op_valid = 0;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_tdata = 128'h7700 + 128'(n_acc - a0);
      tick();
    end
    alt_chk = 0;
    check("stream_count", n_acc - a0, 20);
    drain();

    // 130 random words with random back-pressure, wrapping the pointers
    a0 = n_acc;
    for (int i = 0; i < 3000; i++) begin
      if ((n_acc - a0) >= 130 && sb.size() == 0) break;
      s_tvalid = ((n_acc - a0) < 130);
      s_tdata  = {$urandom, $urandom, $urandom, $urandom};
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    s_tvalid = 1'b0;
    check("rand_count", n_acc - a0, 130);
    check("rand_empty", sb.size(), 0);
    check("rand_wr_ptr", dut.wr_ptr_q, n_acc % 64);
    check("rand_rd_ptr", dut.rd_ptr_q, n_acc % 64);
    drain();

    // Reset while a read is in flight
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(128'h900 + 128'(i));
    repeat (4) tick();
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    #1;
    check("inflight_rd_issue", {sram_csb, sram_web}, 2'b01);
    check("inflight_level", fifo_level, 5);
    @(negedge axis_clk);
    axis_rst = 1'b1;
    @(negedge axis_clk);
    axis_rst = 1'b0;
    sb.delete();
    #1;
    check("rst2_level", fifo_level, 0);
    check("rst2_m_tvalid", m_tvalid, 1'b0);
    check("rst2_csb", sram_csb, 1'b1);
    check("rst2_s_tready", s_tready, 1'b1);
    p0 = n_pop;
    push_word(128'h55);
    drain();
    check("rst2_one_word", n_pop - p0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
